// File: rtl/int_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_issue_queue_pkg
// Description : Shared tag/ROB widths, issue-queue entry type, wakeup helper.
// Revision    : 1.0 - initial release
// ============================================================================
package int_issue_queue_pkg;

  localparam int PRF_WIDTH     = 6;
  localparam int ROB_WIDTH     = 4;
  localparam int CONTROL_WIDTH = 8;
  localparam int ISQ_DEPTH     = 8;
  localparam int ISQ_LEFT_MAX  = 3;

  typedef logic [CONTROL_WIDTH-1:0] control_type;
  typedef logic [PRF_WIDTH-1:0]     prf_tag_t;
  typedef logic [ROB_WIDTH:0]       robid_t;

  typedef struct packed {
    control_type control;
    prf_tag_t    T;
    prf_tag_t    src1;
    prf_tag_t    src2;
    robid_t      robid;
    logic        rdy1;
    logic        rdy2;
  } isq_entry_t;

  // True when either writeback port broadcasts the given tag this cycle.
  function automatic logic tag_wakeup(input prf_tag_t tag,
                                      input logic     wb_valid_0,
                                      input prf_tag_t wb_tag_0,
                                      input logic     wb_valid_1,
                                      input prf_tag_t wb_tag_1);
    return (wb_valid_0 && (wb_tag_0 == tag)) || (wb_valid_1 && (wb_tag_1 == tag));
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : int_issue_queue_if
// Description : Dispatch, wakeup and issue signals of the integer issue queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface int_issue_queue_if;
  import int_issue_queue_pkg::*;

  logic        flush_valid;

  logic        instr0_valid_intisq;
  logic        instr1_valid_intisq;
  control_type instr0_control;
  control_type instr1_control;
  prf_tag_t    instr0_T;
  prf_tag_t    instr1_T;
  prf_tag_t    instr0_src1;
  prf_tag_t    instr0_src2;
  prf_tag_t    instr1_src1;
  prf_tag_t    instr1_src2;
  logic        isq_src1_busy_0;
  logic        isq_src2_busy_0;
  logic        isq_src1_busy_1;
  logic        isq_src2_busy_1;
  robid_t      isq_robid_0;
  robid_t      isq_robid_1;

  logic        wb_valid_0;
  logic        wb_valid_1;
  prf_tag_t    wb_tag_0;
  prf_tag_t    wb_tag_1;

  logic        issue_ready;
  logic        issue_valid;
  control_type issue_control;
  prf_tag_t    issue_T;
  prf_tag_t    issue_src1;
  prf_tag_t    issue_src2;
  robid_t      issue_robid;
  logic [1:0]  intisq_left;

  modport master (
    output flush_valid,
    output instr0_valid_intisq, instr1_valid_intisq, instr0_control, instr1_control,
    output instr0_T, instr1_T, instr0_src1, instr0_src2, instr1_src1, instr1_src2,
    output isq_src1_busy_0, isq_src2_busy_0, isq_src1_busy_1, isq_src2_busy_1,
    output isq_robid_0, isq_robid_1,
    output wb_valid_0, wb_valid_1, wb_tag_0, wb_tag_1,
    output issue_ready,
    input  issue_valid, issue_control, issue_T, issue_src1, issue_src2, issue_robid,
    input  intisq_left
  );

  modport slave (
    input  flush_valid,
    input  instr0_valid_intisq, instr1_valid_intisq, instr0_control, instr1_control,
    input  instr0_T, instr1_T, instr0_src1, instr0_src2, instr1_src1, instr1_src2,
    input  isq_src1_busy_0, isq_src2_busy_0, isq_src1_busy_1, isq_src2_busy_1,
    input  isq_robid_0, isq_robid_1,
    input  wb_valid_0, wb_valid_1, wb_tag_0, wb_tag_1,
    input  issue_ready,
    output issue_valid, issue_control, issue_T, issue_src1, issue_src2, issue_robid,
    output intisq_left
  );

endinterface
`default_nettype wire

// File: rtl/int_issue_queue_isq_select.sv
`default_nettype none
// ============================================================================
// Module      : isq_select
// Description : Lowest-index priority encoder over per-slot ready requests.
// Revision    : 1.0 - initial release
// ============================================================================
module isq_select #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan downward so the lowest (oldest) requesting slot is the last writer.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/int_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : int_issue_queue
// Description : Compacting, age-ordered integer issue queue with wakeup/bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module int_issue_queue #(
  parameter int ISQ_DEPTH = int_issue_queue_pkg::ISQ_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  int_issue_queue_if.slave  isq
);
  import int_issue_queue_pkg::*;

  localparam int         IDX_W      = $clog2(ISQ_DEPTH);
  localparam int         CNT_W      = $clog2(ISQ_DEPTH + 1);
  localparam logic [1:0] RESET_LEFT = (ISQ_DEPTH >= ISQ_LEFT_MAX) ? 2'(ISQ_LEFT_MAX) : 2'(ISQ_DEPTH);

  isq_entry_t       entries_q [ISQ_DEPTH];
  isq_entry_t       entries_d [ISQ_DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       left_q, left_d;

  isq_entry_t       woken   [ISQ_DEPTH];
  isq_entry_t       shifted [ISQ_DEPTH];
  isq_entry_t       new0, new1, first_new;
  logic [ISQ_DEPTH-1:0] ready_vec;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             deq;
  logic [CNT_W-1:0] base, base_p1;
  logic [1:0]       n_enq;
  logic             overflow;
  int               free_slots;

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < ISQ_DEPTH; i++) begin
      ready_vec[i] = (CNT_W'(i) < count_q) && entries_q[i].rdy1 && entries_q[i].rdy2;
    end
  end

  isq_select #(
    .DEPTH (ISQ_DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .req   (ready_vec),
    .idx   (sel_idx),
    .found (sel_found)
  );

  assign isq.issue_valid   = sel_found;
  assign isq.issue_control = entries_q[sel_idx].control;
  assign isq.issue_T       = entries_q[sel_idx].T;
  assign isq.issue_src1    = entries_q[sel_idx].src1;
  assign isq.issue_src2    = entries_q[sel_idx].src2;
  assign isq.issue_robid   = entries_q[sel_idx].robid;
  assign isq.intisq_left   = left_q;

  assign deq = sel_found && isq.issue_ready;

  // Incoming micro-ops see this cycle's broadcasts too, so a tag produced in
  // the dispatch cycle is never missed.
  always_comb begin
    new0 = '{control: isq.instr0_control, T: isq.instr0_T,
             src1: isq.instr0_src1, src2: isq.instr0_src2, robid: isq.isq_robid_0,
             rdy1: !isq.isq_src1_busy_0 ||
                   tag_wakeup(isq.instr0_src1, isq.wb_valid_0, isq.wb_tag_0, isq.wb_valid_1, isq.wb_tag_1),
             rdy2: !isq.isq_src2_busy_0 ||
                   tag_wakeup(isq.instr0_src2, isq.wb_valid_0, isq.wb_tag_0, isq.wb_valid_1, isq.wb_tag_1)};
    new1 = '{control: isq.instr1_control, T: isq.instr1_T,
             src1: isq.instr1_src1, src2: isq.instr1_src2, robid: isq.isq_robid_1,
             rdy1: !isq.isq_src1_busy_1 ||
                   tag_wakeup(isq.instr1_src1, isq.wb_valid_0, isq.wb_tag_0, isq.wb_valid_1, isq.wb_tag_1),
             rdy2: !isq.isq_src2_busy_1 ||
                   tag_wakeup(isq.instr1_src2, isq.wb_valid_0, isq.wb_tag_0, isq.wb_valid_1, isq.wb_tag_1)};
    first_new = isq.instr0_valid_intisq ? new0 : new1;
  end

  always_comb begin
    woken = entries_q;
    for (int i = 0; i < ISQ_DEPTH; i++) begin
      woken[i].rdy1 = entries_q[i].rdy1 ||
                      tag_wakeup(entries_q[i].src1, isq.wb_valid_0, isq.wb_tag_0, isq.wb_valid_1, isq.wb_tag_1);
      woken[i].rdy2 = entries_q[i].rdy2 ||
                      tag_wakeup(entries_q[i].src2, isq.wb_valid_0, isq.wb_tag_0, isq.wb_valid_1, isq.wb_tag_1);
    end

    // Close the gap left by the issued slot; the top slot keeps stale payload
    // which is harmless because it sits at or above the new count.
    shifted = woken;
    for (int i = 0; i < ISQ_DEPTH - 1; i++) begin
      if (deq && (IDX_W'(i) >= sel_idx)) begin
        shifted[i] = woken[i + 1];
      end
    end

    base     = count_q - CNT_W'(deq);
    base_p1  = base + CNT_W'(1);
    n_enq    = {1'b0, isq.instr0_valid_intisq} + {1'b0, isq.instr1_valid_intisq};
    overflow = (int'(base) + int'(n_enq)) > ISQ_DEPTH;

    entries_d = shifted;
    if (!overflow) begin
      for (int i = 0; i < ISQ_DEPTH; i++) begin
        if ((n_enq != 2'd0) && (CNT_W'(i) == base)) begin
          entries_d[i] = first_new;
        end
        if ((n_enq == 2'd2) && (CNT_W'(i) == base_p1)) begin
          entries_d[i] = new1;
        end
      end
    end

    count_d = overflow ? base : (base + CNT_W'(n_enq));
    if (isq.flush_valid) begin
      count_d = '0;
    end

    free_slots = ISQ_DEPTH - int'(count_d);
    left_d     = (free_slots >= ISQ_LEFT_MAX) ? 2'(ISQ_LEFT_MAX) : 2'(free_slots);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      left_q  <= RESET_LEFT;
    end else begin
      count_q <= count_d;
      left_q  <= left_d;
    end
  end

  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  a_no_enqueue_overflow: assert property (@(posedge clk) disable iff (reset)
    (isq.flush_valid || !overflow));

endmodule
`default_nettype wire

// File: tb/tb_int_issue_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_int_issue_queue
// Description : Directed stimulus with a queue-based reference model and literal pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_issue_queue;
  import int_issue_queue_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int_issue_queue_if bus ();

  int_issue_queue #(.ISQ_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .isq   (bus.slave)
  );

  typedef struct {
    control_type control;
    prf_tag_t    t;
    prf_tag_t    s1;
    prf_tag_t    s2;
    robid_t      robid;
    bit          r1;
    bit          r2;
  } m_ent_t;

  m_ent_t mq[$];
  m_ent_t m_new;
  int     m_left;
  int     m_sel_idx;
  int     cmp_sel;
  bit     model_live = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int m_sel();
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].r1 && mq[i].r2) return i;
    end
    return -1;
  endfunction

  function automatic bit m_wake(input prf_tag_t t);
    return (bus.wb_valid_0 && bus.wb_tag_0 == t) || (bus.wb_valid_1 && bus.wb_tag_1 == t);
  endfunction

  // Reference model: an age-ordered list updated once per rising edge.
  always @(posedge clk) begin
    if (reset || bus.flush_valid) begin
      mq.delete();
      model_live = 1'b1;
    end else begin
      m_sel_idx = m_sel();
      for (int i = 0; i < mq.size(); i++) begin
        if (m_wake(mq[i].s1)) mq[i].r1 = 1'b1;
        if (m_wake(mq[i].s2)) mq[i].r2 = 1'b1;
      end
      if (m_sel_idx >= 0 && bus.issue_ready) mq.delete(m_sel_idx);
      if (bus.instr0_valid_intisq) begin
        m_new.control = bus.instr0_control; m_new.t = bus.instr0_T;
        m_new.s1 = bus.instr0_src1; m_new.s2 = bus.instr0_src2; m_new.robid = bus.isq_robid_0;
        m_new.r1 = !bus.isq_src1_busy_0 || m_wake(bus.instr0_src1);
        m_new.r2 = !bus.isq_src2_busy_0 || m_wake(bus.instr0_src2);
        mq.push_back(m_new);
      end
      if (bus.instr1_valid_intisq) begin
        m_new.control = bus.instr1_control; m_new.t = bus.instr1_T;
        m_new.s1 = bus.instr1_src1; m_new.s2 = bus.instr1_src2; m_new.robid = bus.isq_robid_1;
        m_new.r1 = !bus.isq_src1_busy_1 || m_wake(bus.instr1_src1);
        m_new.r2 = !bus.isq_src2_busy_1 || m_wake(bus.instr1_src2);
        mq.push_back(m_new);
      end
    end
    m_left = (DEPTH - mq.size() > 3) ? 3 : DEPTH - mq.size();
  end

  // Compare process: outputs against the model every cycle, mid-period.
  always @(negedge clk) begin
    if (model_live) begin
      cmp_sel = m_sel();
      check("issue_valid", bus.issue_valid, (cmp_sel >= 0) ? 1 : 0);
      check("intisq_left", bus.intisq_left, m_left);
      if (cmp_sel >= 0) begin
        check("issue_T",       bus.issue_T,       mq[cmp_sel].t);
        check("issue_src1",    bus.issue_src1,    mq[cmp_sel].s1);
        check("issue_src2",    bus.issue_src2,    mq[cmp_sel].s2);
        check("issue_robid",   bus.issue_robid,   mq[cmp_sel].robid);
        check("issue_control", bus.issue_control, mq[cmp_sel].control);
      end
    end
  end

  task automatic idle();
    bus.flush_valid = 1'b0;
    bus.instr0_valid_intisq = 1'b0; bus.instr1_valid_intisq = 1'b0;
    bus.instr0_control = '0; bus.instr1_control = '0;
    bus.instr0_T = '0; bus.instr1_T = '0;
    bus.instr0_src1 = '0; bus.instr0_src2 = '0; bus.instr1_src1 = '0; bus.instr1_src2 = '0;
    bus.isq_src1_busy_0 = 1'b0; bus.isq_src2_busy_0 = 1'b0;
    bus.isq_src1_busy_1 = 1'b0; bus.isq_src2_busy_1 = 1'b0;
    bus.isq_robid_0 = '0; bus.isq_robid_1 = '0;
    bus.wb_valid_0 = 1'b0; bus.wb_valid_1 = 1'b0; bus.wb_tag_0 = '0; bus.wb_tag_1 = '0;
    bus.issue_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq0(input prf_tag_t t, input prf_tag_t s1, input logic b1,
                      input prf_tag_t s2, input logic b2, input robid_t r);
    bus.instr0_valid_intisq = 1'b1; bus.instr0_control = control_type'(t) ^ 8'h5A;
    bus.instr0_T = t; bus.instr0_src1 = s1; bus.instr0_src2 = s2;
    bus.isq_src1_busy_0 = b1; bus.isq_src2_busy_0 = b2; bus.isq_robid_0 = r;
  endtask

  task automatic enq1(input prf_tag_t t, input prf_tag_t s1, input logic b1,
                      input prf_tag_t s2, input logic b2, input robid_t r);
    bus.instr1_valid_intisq = 1'b1; bus.instr1_control = control_type'(t) ^ 8'hC3;
    bus.instr1_T = t; bus.instr1_src1 = s1; bus.instr1_src2 = s2;
    bus.isq_src1_busy_1 = b1; bus.isq_src2_busy_1 = b2; bus.isq_robid_1 = r;
  endtask

  int       exp_left_fill [4];
  prf_tag_t wake_a [8];
  prf_tag_t wake_b [8];
  int       drained [$];

  initial begin
    exp_left_fill = '{3, 3, 2, 0};
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_issue_valid", bus.issue_valid, 0);
    check("rst_left", bus.intisq_left, 3);

    // Single ready op: visible next cycle, gone the cycle after.
    enq0(6'd5, 6'd1, 1'b0, 6'd2, 1'b0, 5'd2);
    bus.issue_ready = 1'b1;
    tick();
    check("t1_valid", bus.issue_valid, 1);
    check("t1_T", bus.issue_T, 5);
    check("t1_left", bus.intisq_left, 3);
    idle(); bus.issue_ready = 1'b1;
    tick();
    check("t1_empty", bus.issue_valid, 0);
    check("t1_left_after", bus.intisq_left, 3);

    // Younger ready op issues first; wakeup then releases the older one.
    idle();
    enq0(6'd10, 6'd7, 1'b1, 6'd8, 1'b0, 5'd3);
    enq1(6'd11, 6'd12, 1'b0, 6'd13, 1'b0, 5'd4);
    tick();
    check("t2_first_T", bus.issue_T, 11);
    idle(); bus.issue_ready = 1'b1; bus.wb_valid_0 = 1'b1; bus.wb_tag_0 = 6'd7;
    tick();
    check("t2_second_valid", bus.issue_valid, 1);
    check("t2_second_T", bus.issue_T, 10);
    idle(); bus.issue_ready = 1'b1;
    tick();
    check("t2_empty", bus.issue_valid, 0);

    // Fill with busy ops, two per cycle.
    for (int k = 0; k < 4; k++) begin
      idle(); bus.issue_ready = 1'b1;
      enq0(prf_tag_t'(40 + 2*k), prf_tag_t'(16 + 2*k), 1'b1, prf_tag_t'(32 + 2*k), 1'b1, robid_t'(2*k));
      enq1(prf_tag_t'(41 + 2*k), prf_tag_t'(17 + 2*k), 1'b1, prf_tag_t'(33 + 2*k), 1'b1, robid_t'(2*k + 1));
      tick();
      check("fill_left", bus.intisq_left, exp_left_fill[k]);
      check("fill_valid", bus.issue_valid, 0);
    end

    // Full queue: issue oldest and enqueue one in the same cycle.
    idle(); bus.wb_valid_0 = 1'b1; bus.wb_tag_0 = 6'd16; bus.wb_valid_1 = 1'b1; bus.wb_tag_1 = 6'd32;
    tick();
    check("full_head_valid", bus.issue_valid, 1);
    check("full_head_robid", bus.issue_robid, 0);
    idle(); bus.issue_ready = 1'b1;
    enq0(6'd50, 6'd50, 1'b1, 6'd51, 1'b1, 5'd8);
    tick();
    check("full_swap_left", bus.intisq_left, 0);
    check("full_swap_valid", bus.issue_valid, 0);

    for (int e = 0; e < 7; e++) begin
      wake_a[e] = prf_tag_t'(17 + e);
      wake_b[e] = prf_tag_t'(33 + e);
    end
    wake_a[7] = 6'd50; wake_b[7] = 6'd51;
    for (int c = 0; c < 30 && drained.size() < 8; c++) begin
      idle(); bus.issue_ready = 1'b1;
      if (c < 8) begin
        bus.wb_valid_0 = 1'b1; bus.wb_tag_0 = wake_a[c];
        bus.wb_valid_1 = 1'b1; bus.wb_tag_1 = wake_b[c];
      end
      tick();
      if (bus.issue_valid) drained.push_back(int'(bus.issue_robid));
    end
    check("drain_count", drained.size(), 8);
    for (int i = 0; i < drained.size(); i++) check("drain_robid_order", drained[i], i + 1);
    idle(); bus.issue_ready = 1'b1;
    tick();
    check("drain_empty", bus.issue_valid, 0);
    check("drain_left", bus.intisq_left, 3);

    // Same-cycle wakeup bypass into a newly enqueued op.
    idle();
    enq0(6'd20, 6'd9, 1'b1, 6'd10, 1'b0, 5'd9);
    bus.wb_valid_1 = 1'b1; bus.wb_tag_1 = 6'd9;
    tick();
    check("bypass_valid", bus.issue_valid, 1);
    check("bypass_T", bus.issue_T, 20);
    idle(); bus.issue_ready = 1'b1;
    tick();
    check("bypass_empty", bus.issue_valid, 0);

    // Five entries, then flush alongside enqueue, issue and wakeup.
    idle();
    enq0(6'd1, 6'd2, 1'b0, 6'd3, 1'b0, 5'd20);
    enq1(6'd2, 6'd60, 1'b1, 6'd61, 1'b0, 5'd21);
    tick();
    idle();
    enq0(6'd3, 6'd62, 1'b1, 6'd4, 1'b0, 5'd22);
    enq1(6'd4, 6'd63, 1'b1, 6'd5, 1'b0, 5'd23);
    tick();
    idle();
    enq0(6'd5, 6'd58, 1'b1, 6'd59, 1'b1, 5'd24);
    tick();
    check("pre_flush_robid", bus.issue_robid, 20);
    check("pre_flush_left", bus.intisq_left, 3);
    idle(); bus.flush_valid = 1'b1; bus.issue_ready = 1'b1;
    enq0(6'd6, 6'd1, 1'b0, 6'd1, 1'b0, 5'd25);
    bus.wb_valid_0 = 1'b1; bus.wb_tag_0 = 6'd60; bus.wb_valid_1 = 1'b1; bus.wb_tag_1 = 6'd62;
    check("flush_cycle_valid", bus.issue_valid, 1);
    tick();
    check("post_flush_valid", bus.issue_valid, 0);
    check("post_flush_left", bus.intisq_left, 3);
    for (int c = 0; c < 3; c++) begin
      idle(); bus.issue_ready = 1'b1;
      bus.wb_valid_0 = 1'b1; bus.wb_tag_0 = prf_tag_t'(58 + 2*c);
      bus.wb_valid_1 = 1'b1; bus.wb_tag_1 = prf_tag_t'(59 + 2*c);
      tick();
    end
    check("flush_no_reissue", bus.issue_valid, 0);

    // Reset in the middle of operation.
    idle();
    enq0(6'd7, 6'd1, 1'b0, 6'd2, 1'b0, 5'd26);
    tick();
    check("pre_reset_valid", bus.issue_valid, 1);
    reset = 1'b1;
    enq0(6'd8, 6'd1, 1'b0, 6'd2, 1'b0, 5'd27);
    tick();
    reset = 1'b0;
    idle();
    check("mid_reset_valid", bus.issue_valid, 0);
    check("mid_reset_left", bus.intisq_left, 3);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
